// File: rtl/invader_sprite_engine.sv
// Space-invader sprite engine: per-invader life-cycle FSM, animation frame
// counter and a one-cycle registered pixel lookup into constant bitmaps.
// Optional feature macro: INVADER_EXPLODE_ANIM_EN adds an EXPLODING state with
// its own bitmap and FrameTick counter. Without it, Hit kills outright.
// The bitmaps are drawn at 22x8 with every art row two scanlines tall, which
// gives a 22x16 sprite. Pixels outside that art area are unlit, and types
// beyond the three drawn ones reuse type 0. The FSM state is visible on
// fsm_state for debug.
module invader_sprite_engine #(
  parameter int SPRITE_W      = 22,
  parameter int SPRITE_H      = 16,
  parameter int NUM_TYPES     = 3,
  parameter int NUM_FRAMES    = 2,
  parameter int ANIM_PERIOD   = 30,
  parameter int EXPLODE_TICKS = 15,
  localparam int TW = (NUM_TYPES  > 1) ? $clog2(NUM_TYPES)  : 1,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic [9:0]    InvaderX,
  input  logic [9:0]    InvaderY,
  input  logic [TW-1:0] InvType,
  input  logic          FrameTick,
  input  logic          Hit,
  input  logic          Respawn,
  output logic          invader_on,
  output logic          exploding,
  output logic          dead,
  output logic [FW-1:0] anim_frame,
  output logic [1:0]    fsm_state
);

  localparam int AW = $clog2(ANIM_PERIOD + 1);
  localparam logic [TW:0] TYPE_LIM = (TW+1)'(NUM_TYPES);
  localparam logic [TW:0] ART_LIM  = (TW+1)'(3);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_EXPLODING = 2'd1,
    ST_DEAD      = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   anim_cnt;
  logic            explode_done;
  logic signed [10:0] col;
  logic signed [10:0] row;
  logic            in_box;
  logic [1:0]      art_type;
  logic [21:0]     art_word;
  logic [21:0]     art_shift;

  // Invader bitmaps: bit 21 is column 0, the leftmost pixel.
  function automatic logic [21:0] invader_art(input logic [1:0] t,
                                              input logic       f,
                                              input logic [2:0] r);
    logic [21:0] w;
    case ({t, f, r})
      // type 0: squid
      6'b00_0_000, 6'b00_1_000: w = 22'b00_0000_0011_1111_0000_0000;
      6'b00_0_001, 6'b00_1_001: w = 22'b00_0011_1111_1111_1100_0000;
      6'b00_0_010, 6'b00_1_010: w = 22'b00_1111_1111_1111_1111_0000;
      6'b00_0_011, 6'b00_1_011: w = 22'b00_1111_0011_1100_1111_0000;
      6'b00_0_100, 6'b00_1_100: w = 22'b00_1111_1111_1111_1111_0000;
      6'b00_0_101: w = 22'b00_0001_1100_0011_1000_0000;
      6'b00_0_110: w = 22'b00_0110_0011_1100_0110_0000;
      6'b00_0_111: w = 22'b00_1100_0000_0000_0011_0000;
      6'b00_1_101: w = 22'b00_0011_1100_0011_1100_0000;
      6'b00_1_110: w = 22'b00_1100_0011_1100_0011_0000;
      6'b00_1_111: w = 22'b00_0011_0000_0000_1100_0000;
      // type 1: crab
      6'b01_0_000: w = 22'b00_0011_0000_0000_1100_0000;
      6'b01_1_000: w = 22'b11_0011_0000_0000_1100_1100;
      6'b01_0_001, 6'b01_1_001: w = 22'b00_0000_1100_0011_0000_0000;
      6'b01_0_010, 6'b01_1_010: w = 22'b00_0011_1111_1111_1100_0000;
      6'b01_0_011, 6'b01_1_011: w = 22'b00_1111_0011_1100_1111_0000;
      6'b01_0_100, 6'b01_1_100: w = 22'b11_1111_1111_1111_1111_1100;
      6'b01_0_101: w = 22'b11_0011_1111_1111_1100_1100;
      6'b01_0_110: w = 22'b11_0011_0000_0000_1100_1100;
      6'b01_0_111: w = 22'b00_0000_1111_1111_0000_0000;
      6'b01_1_101: w = 22'b00_1111_1111_1111_1111_0000;
      6'b01_1_110: w = 22'b00_0011_0000_0000_1100_0000;
      6'b01_1_111: w = 22'b00_1100_0000_0000_0011_0000;
      // type 2: octopus
      6'b10_0_000, 6'b10_1_000: w = 22'b00_0000_1111_1111_0000_0000;
      6'b10_0_001, 6'b10_1_001: w = 22'b00_1111_1111_1111_1111_0000;
      6'b10_0_010, 6'b10_1_010: w = 22'b11_1111_1111_1111_1111_1100;
      6'b10_0_011, 6'b10_1_011: w = 22'b11_1100_0011_1100_0011_1100;
      6'b10_0_100, 6'b10_1_100: w = 22'b11_1111_1111_1111_1111_1100;
      6'b10_0_101, 6'b10_1_101: w = 22'b00_0011_1100_0011_1100_0000;
      6'b10_0_110: w = 22'b00_1100_0011_1100_0011_0000;
      6'b10_0_111: w = 22'b11_0000_0000_0000_0000_1100;
      6'b10_1_110: w = 22'b00_1111_0000_0000_1111_0000;
      6'b10_1_111: w = 22'b00_0011_0000_0000_1100_0000;
      default:     w = 22'b0;
    endcase
    return w;
  endfunction

`ifdef INVADER_EXPLODE_ANIM_EN
  localparam int EW = $clog2(EXPLODE_TICKS + 1);
  logic [EW-1:0] explode_cnt;

  // Single explosion burst shared by every type and frame.
  function automatic logic [21:0] explode_art(input logic [2:0] r);
    logic [21:0] w;
    case (r)
      3'd0:    w = 22'b00_1000_0100_1000_0100_0000;
      3'd1:    w = 22'b00_0100_0010_0100_1000_0000;
      3'd2:    w = 22'b00_0010_0000_0001_0000_0000;
      3'd3:    w = 22'b11_0000_0000_0000_0000_1100;
      3'd4:    w = 22'b00_0010_0000_0001_0000_0000;
      3'd5:    w = 22'b00_0100_1000_0100_1000_0000;
      3'd6:    w = 22'b00_1000_0100_1000_0100_0000;
      default: w = 22'b0;
    endcase
    return w;
  endfunction

  // Explode counter: held at 0 outside EXPLODING, so entering the state starts it from 0.
  always_ff @(posedge Clk) begin
    if (Reset || Respawn || state != ST_EXPLODING) explode_cnt <= '0;
    else if (FrameTick) explode_cnt <= explode_cnt + 1'b1;
  end

  assign explode_done = FrameTick && (explode_cnt == EW'(EXPLODE_TICKS - 1));
  assign exploding    = (state == ST_EXPLODING);
`else
  assign explode_done = 1'b0;
  assign exploding    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_ALIVE;
    else       state <= state_next;
  end

  // Next state: Respawn wins over everything, and Hit only matters in ALIVE.
  always_comb begin
    state_next = state;
    if (Respawn) begin
      state_next = ST_ALIVE;
    end else begin
      case (state)
`ifdef INVADER_EXPLODE_ANIM_EN
        ST_ALIVE:     if (Hit) state_next = ST_EXPLODING;
`else
        ST_ALIVE:     if (Hit) state_next = ST_DEAD;
`endif
        ST_EXPLODING: if (explode_done) state_next = ST_DEAD;
        default:      state_next = state;
      endcase
    end
  end

  // Animation counter: steps on FrameTicks while alive and advances the frame each period.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim_cnt   <= '0;
      anim_frame <= '0;
    end else if (state == ST_ALIVE && FrameTick) begin
      if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
        anim_cnt   <= '0;
        anim_frame <= (anim_frame == FW'(NUM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // Relative position in 11-bit signed space, so screen-edge wrap never lands in the box.
  assign col    = $signed({1'b0, DrawX}) - $signed({1'b0, InvaderX});
  assign row    = $signed({1'b0, DrawY}) - $signed({1'b0, InvaderY});
  assign in_box = !col[10] && (col[9:0] < 10'(SPRITE_W)) &&
                  !row[10] && (row[9:0] < 10'(SPRITE_H));

  // Bitmap row selection: out-of-range types fall back to type 0, and the explosion overrides all.
  always_comb begin
    art_type = 2'd0;
    if (({1'b0, InvType} < TYPE_LIM) && ({1'b0, InvType} < ART_LIM))
      art_type = 2'(InvType);
    art_word = invader_art(art_type, anim_frame[0], row[3:1]);
`ifdef INVADER_EXPLODE_ANIM_EN
    if (state == ST_EXPLODING) art_word = explode_art(row[3:1]);
`endif
    if (row[4]) art_word = '0;
  end

  // Shifting left by col puts the addressed pixel in bit 21; columns past 21 shift out to 0.
  assign art_shift = art_word << col[4:0];

  // Single output register: pixel lit only inside the box and while not dead.
  always_ff @(posedge Clk) begin
    if (Reset) invader_on <= 1'b0;
    else       invader_on <= in_box && (state != ST_DEAD) && art_shift[21];
  end

  assign dead      = (state == ST_DEAD);
  assign fsm_state = state;

endmodule

// File: tb/tb_invader_sprite_engine.sv
// Directed testbench for invader_sprite_engine (default parameters).
module tb_invader_sprite_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, InvaderX = '0, InvaderY = '0;
  logic [1:0] InvType = '0;
  logic       FrameTick = 1'b0, Hit = 1'b0, Respawn = 1'b0;
  logic       invader_on, exploding, dead;
  logic [0:0] anim_frame;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  invader_sprite_engine dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .InvaderX(InvaderX), .InvaderY(InvaderY), .InvType(InvType),
    .FrameTick(FrameTick), .Hit(Hit), .Respawn(Respawn),
    .invader_on(invader_on), .exploding(exploding), .dead(dead),
    .anim_frame(anim_frame), .fsm_state(fsm_state)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      FrameTick = 1'b1;
      step();
      FrameTick = 1'b0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %0b expected 0", invader_on); end
    checks++; if (exploding !== 1'b0) begin errors++; $display("FAIL reset_exploding: got %0b expected 0", exploding); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead: got %0b expected 0", dead); end
    checks++; if (anim_frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %0d expected 0", anim_frame); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
  endtask

  typedef struct {
    int         dx;
    int         dy;
    logic [1:0] t;
    logic       exp;
  } pix_vec_t;

  task automatic test_pixels();
    pix_vec_t v[17];
    v[0]  = '{100, 50, 2'd0, 1'b0};  // type0 row0 col0
    v[1]  = '{108, 50, 2'd0, 1'b1};  // first lit column of squid head
    v[2]  = '{107, 50, 2'd0, 1'b0};
    v[3]  = '{113, 50, 2'd0, 1'b1};
    v[4]  = '{114, 50, 2'd0, 1'b0};
    v[5]  = '{100, 58, 2'd1, 1'b1};  // crab art row4 col0
    v[6]  = '{100, 58, 2'd0, 1'b0};
    v[7]  = '{102, 52, 2'd2, 1'b1};  // octopus art row1 col2
    v[8]  = '{102, 52, 2'd0, 1'b0};
    v[9]  = '{108, 50, 2'd3, 1'b1};  // type 3 renders type 0
    v[10] = '{100, 58, 2'd3, 1'b0};
    v[11] = '{ 99, 54, 2'd2, 1'b0};  // col -1
    v[12] = '{100, 55, 2'd2, 1'b1};  // art row2 via second scanline
    v[13] = '{100, 65, 2'd2, 1'b1};  // last row inside box
    v[14] = '{100, 66, 2'd2, 1'b0};  // first row below box
    v[15] = '{119, 54, 2'd2, 1'b1};
    v[16] = '{122, 54, 2'd2, 1'b0};  // col == SPRITE_W
    InvaderX = 10'd100;
    InvaderY = 10'd50;
    for (int i = 0; i < 17; i++) begin
      DrawX   = 10'(v[i].dx);
      DrawY   = 10'(v[i].dy);
      InvType = v[i].t;
      step();
      checks++;
      if (invader_on !== v[i].exp) begin
        errors++;
        $display("FAIL pixel_%0d (x=%0d y=%0d t=%0d): got %0b expected %0b",
                 i, v[i].dx, v[i].dy, v[i].t, invader_on, v[i].exp);
      end
    end
  endtask

  task automatic test_latency();
    InvaderX = 10'd100; InvaderY = 10'd50; InvType = 2'd0;
    DrawX = 10'd108; DrawY = 10'd50;
    step();
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL latency_lit: got %0b expected 1", invader_on); end
    DrawX = 10'd100;
    #2;
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL latency_hold: got %0b expected 1", invader_on); end
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL latency_clear: got %0b expected 0", invader_on); end
  endtask

  task automatic test_no_wrap();
    InvType = 2'd0; InvaderY = 10'd50; DrawY = 10'd50;
    InvaderX = 10'd5; DrawX = 10'd1020;
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL nowrap_1020: got %0b expected 0", invader_on); end
    InvaderX = 10'd1015; DrawX = 10'd3;
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL nowrap_edge: got %0b expected 0", invader_on); end
    InvaderX = 10'd5; DrawX = 10'd27;
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL right_edge: got %0b expected 0", invader_on); end
    DrawX = 10'd18;
    step();
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL small_anchor: got %0b expected 1", invader_on); end
  endtask

  task automatic test_anim();
    do_reset();
    InvaderX = 10'd100; InvaderY = 10'd50; InvType = 2'd0;
    DrawX = 10'd104; DrawY = 10'd60;  // squid art row5 col4: unlit in frame 0, lit in frame 1
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL anim_pix_f0: got %0b expected 0", invader_on); end
    tick_frames(29);
    checks++; if (anim_frame !== 1'b0) begin errors++; $display("FAIL anim_29: got %0d expected 0", anim_frame); end
    tick_frames(1);
    checks++; if (anim_frame !== 1'b1) begin errors++; $display("FAIL anim_30: got %0d expected 1", anim_frame); end
    step();
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL anim_pix_f1: got %0b expected 1", invader_on); end
    tick_frames(29);
    checks++; if (anim_frame !== 1'b1) begin errors++; $display("FAIL anim_59: got %0d expected 1", anim_frame); end
    tick_frames(1);
    checks++; if (anim_frame !== 1'b0) begin errors++; $display("FAIL anim_60: got %0d expected 0", anim_frame); end
  endtask

  task automatic test_hit_respawn_same();
    Hit = 1'b1; Respawn = 1'b1;
    step();
    Hit = 1'b0; Respawn = 1'b0;
    checks++; if (exploding !== 1'b0) begin errors++; $display("FAIL hr_exploding: got %0b expected 0", exploding); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL hr_dead: got %0b expected 0", dead); end
    step();
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL hr_state: got %0d expected 0", fsm_state); end
  endtask

`ifdef INVADER_EXPLODE_ANIM_EN
  task automatic test_kill();
    InvaderX = 10'd100; InvaderY = 10'd50; InvType = 2'd0;
    DrawX = 10'd102; DrawY = 10'd50;  // explosion row0 col2 is lit, squid row0 col2 is not
    Hit = 1'b1;
    step();
    Hit = 1'b0;
    checks++; if (exploding !== 1'b1) begin errors++; $display("FAIL explode_enter: got %0b expected 1", exploding); end
    step();
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL explode_pix: got %0b expected 1", invader_on); end
    for (int i = 1; i <= 14; i++) begin
      tick_frames(1);
      checks++;
      if (exploding !== 1'b1 || dead !== 1'b0) begin
        errors++;
        $display("FAIL explode_tick_%0d: got exploding=%0b dead=%0b expected 1/0", i, exploding, dead);
      end
    end
    tick_frames(1);
    checks++; if (dead !== 1'b1 || exploding !== 1'b0) begin errors++; $display("FAIL explode_done: got dead=%0b exploding=%0b expected 1/0", dead, exploding); end
  endtask
`else
  task automatic test_kill();
    Hit = 1'b1;
    step();
    Hit = 1'b0;
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL kill_dead: got %0b expected 1", dead); end
    checks++; if (exploding !== 1'b0) begin errors++; $display("FAIL kill_exploding: got %0b expected 0", exploding); end
    step();
    checks++; if (exploding !== 1'b0) begin errors++; $display("FAIL kill_exploding_hold: got %0b expected 0", exploding); end
  endtask
`endif

  task automatic test_dead();
    InvaderX = 10'd100; InvaderY = 10'd50; InvType = 2'd0;
    DrawX = 10'd108; DrawY = 10'd50;
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL dead_pix: got %0b expected 0", invader_on); end
    DrawX = 10'd102; DrawY = 10'd54;
    step();
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL dead_pix2: got %0b expected 0", invader_on); end
    Hit = 1'b1;
    step();
    Hit = 1'b0;
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL dead_hit_ignored: got %0b expected 1", dead); end
    tick_frames(30);
    checks++; if (anim_frame !== 1'b0) begin errors++; $display("FAIL dead_anim_frozen: got %0d expected 0", anim_frame); end
    Respawn = 1'b1;
    step();
    Respawn = 1'b0;
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL respawn_dead: got %0b expected 0", dead); end
    DrawX = 10'd108; DrawY = 10'd50;
    step();
    checks++; if (invader_on !== 1'b1) begin errors++; $display("FAIL respawn_pix: got %0b expected 1", invader_on); end
  endtask

  task automatic test_reset_override();
    tick_frames(30);
    checks++; if (anim_frame !== 1'b1) begin errors++; $display("FAIL ovr_pre_frame: got %0d expected 1", anim_frame); end
    Hit = 1'b1;
    step();
    Hit = 1'b0;
    DrawX = 10'd108; DrawY = 10'd50;
    Reset = 1'b1; Hit = 1'b1; Respawn = 1'b1; FrameTick = 1'b1;
    step();
    Reset = 1'b0; Hit = 1'b0; Respawn = 1'b0; FrameTick = 1'b0;
    checks++; if (dead !== 1'b0 || exploding !== 1'b0) begin errors++; $display("FAIL ovr_state: got dead=%0b exploding=%0b expected 0/0", dead, exploding); end
    checks++; if (anim_frame !== 1'b0) begin errors++; $display("FAIL ovr_frame: got %0d expected 0", anim_frame); end
    checks++; if (invader_on !== 1'b0) begin errors++; $display("FAIL ovr_on: got %0b expected 0", invader_on); end
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_latency();
    test_no_wrap();
    test_anim();
    test_hit_respawn_same();
    test_kill();
    test_dead();
    test_reset_override();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
